// File: rtl/sbqm_pkg.sv
// sbqm_pkg: shared types and default timing constants for the bank-queue event arbiter.
package sbqm_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;
    typedef enum logic {SIDE_UP, SIDE_DOWN} side_e;

    localparam int DEF_DEB_CYCLES = 4;
    localparam int DEF_GAP_CYCLES = 2;
    localparam int DEF_PEND_W     = 3;

endpackage

// File: rtl/sbqm_sensor_cond.sv
// sbqm_sensor_cond: synchronizes, debounces and falling-edge-detects one active-low photocell.
module sbqm_sensor_cond
    import sbqm_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic ResetN,
    input  logic sens_n,
    output logic fall
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    sync_q, sync_d;
    logic          deb_q, deb_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          flip;

    // cnt_q counts consecutive synchronized samples that disagree with the debounced level
    always_comb begin
        sync_d = {sync_q[0], sens_n};
        flip   = (sync_q[1] != deb_q) && (cnt_q == CW'(DEB_CYCLES - 1));
        cnt_d  = (sync_q[1] == deb_q || flip) ? '0 : cnt_q + 1'b1;
        deb_d  = flip ? sync_q[1] : deb_q;
        fall_d = deb_q & ~deb_d;
    end

    always_ff @(posedge clk or negedge ResetN) begin
        if (!ResetN) begin
            sync_q <= '1;
            deb_q  <= 1'b1;
            cnt_q  <= '0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
            fall_q <= fall_d;
        end
    end

    assign fall = fall_q;

endmodule

// File: rtl/sbqm_event_arbiter.sv
// sbqm_event_arbiter: buffers entry/exit events and issues exclusive Up/Down strobes to the occupancy counter.
module sbqm_event_arbiter
    import sbqm_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int PEND_W     = DEF_PEND_W
) (
    input  logic              clk,
    input  logic              ResetN,
    input  logic              EntrySensN,
    input  logic              ExitSensN,
    input  logic              Full,
    input  logic              Empty,
    output logic              UpStrobe,
    output logic              DownStrobe,
    output logic              RejectFull,
    output logic              UnderflowErr,
    output logic              OverrunErr,
    output logic [PEND_W-1:0] PendUp,
    output logic [PEND_W-1:0] PendDown
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [PEND_W-1:0] PMAX = '1;

    logic              ev_up, ev_dn;
    state_e            state_q, state_d;
    side_e             last_q, last_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [PEND_W-1:0] pend_up_q, pend_up_d, pend_dn_q, pend_dn_d;
    logic              up_q, up_d, dn_q, dn_d, rej_q, rej_d, unf_q, unf_d, ovr_q, ovr_d;
    logic              req_up, req_dn, decide, serve_up, serve_dn, grant_up, grant_dn;
    logic              ovf_up, ovf_dn;

    sbqm_sensor_cond #(.DEB_CYCLES(DEB_CYCLES)) u_entry (
        .clk(clk), .ResetN(ResetN), .sens_n(EntrySensN), .fall(ev_up)
    );

    sbqm_sensor_cond #(.DEB_CYCLES(DEB_CYCLES)) u_exit (
        .clk(clk), .ResetN(ResetN), .sens_n(ExitSensN), .fall(ev_dn)
    );

    // An event arriving this cycle is already a request, so an idle arbiter strobes one clock later.
    // The last gap clock doubles as the decision cycle, giving strobe spacing of GAP_CYCLES+1.
    always_comb begin
        req_up    = ev_up | (pend_up_q != '0);
        req_dn    = ev_dn | (pend_dn_q != '0);
        decide    = (state_q == IDLE) || (state_q == GAP && gap_q == GW'(GAP_CYCLES - 1));
        serve_up  = decide & req_up & (~req_dn | (last_q == SIDE_DOWN));
        serve_dn  = decide & req_dn & ~serve_up;
        grant_up  = serve_up & ~Full;
        grant_dn  = serve_dn & ~Empty;
        ovf_up    = ev_up & ~serve_up & (pend_up_q == PMAX);
        ovf_dn    = ev_dn & ~serve_dn & (pend_dn_q == PMAX);
        pend_up_d = (ev_up & ~serve_up & ~ovf_up) ? pend_up_q + 1'b1 :
                    (serve_up & ~ev_up) ? pend_up_q - 1'b1 : pend_up_q;
        pend_dn_d = (ev_dn & ~serve_dn & ~ovf_dn) ? pend_dn_q + 1'b1 :
                    (serve_dn & ~ev_dn) ? pend_dn_q - 1'b1 : pend_dn_q;
        state_d   = (grant_up | grant_dn) ? GRANT :
                    (state_q == GRANT) ? GAP :
                    decide ? IDLE : state_q;
        gap_d     = (state_q == GAP) ? gap_q + 1'b1 : '0;
        last_d    = grant_up ? SIDE_UP : grant_dn ? SIDE_DOWN : last_q;
        up_d      = grant_up;
        dn_d      = grant_dn;
        rej_d     = serve_up & Full;
        unf_d     = unf_q | (serve_dn & Empty);
        ovr_d     = ovr_q | ovf_up | ovf_dn;
    end

    always_ff @(posedge clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q   <= IDLE;
            last_q    <= SIDE_DOWN;
            gap_q     <= '0;
            pend_up_q <= '0;
            pend_dn_q <= '0;
            up_q      <= 1'b0;
            dn_q      <= 1'b0;
            rej_q     <= 1'b0;
            unf_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gap_q     <= gap_d;
            pend_up_q <= pend_up_d;
            pend_dn_q <= pend_dn_d;
            up_q      <= up_d;
            dn_q      <= dn_d;
            rej_q     <= rej_d;
            unf_q     <= unf_d;
            ovr_q     <= ovr_d;
        end
    end

    assign UpStrobe     = up_q;
    assign DownStrobe   = dn_q;
    assign RejectFull   = rej_q;
    assign UnderflowErr = unf_q;
    assign OverrunErr   = ovr_q;
    assign PendUp       = pend_up_q;
    assign PendDown     = pend_dn_q;

endmodule
